aes_uart_frame_rx: RTL and testbench
====================================

// Module: aes_uart_frame_rx
// PURPOSE
//   Upstream stage of the AES core. Assembles UART RX bytes into command
//   frames and drives the core's start/decrypt/key/text inputs. Frame = one
//   command byte + 16 payload bytes, MSB first. The command byte selects one of:
//     - load key
//     - encrypt
//     - decrypt
//   The block holds off new frames until the core reports done.
// PARAMETERS
//   TIMEOUT_CYC  100000  idle cycles allowed between payload bytes before abort
//   CMD_KEY      8'h4B   command byte: load 128-bit key
//   CMD_ENC      8'h45   command byte: encrypt payload
//   CMD_DEC      8'h44   command byte: decrypt payload
// PORTS
//   i_Clk      in   1    system clock, rising edge
//   i_Rst      in   1    asynchronous active-low reset
//   i_RxValid  in   1    one-cycle strobe: i_RxData holds a received byte
//   i_RxData   in   8    received UART byte
//   i_AesDone  in   1    AES core done strobe (from core fDone)
//   o_Start    out  1    one-cycle start pulse to AES core
//   o_fDec     out  1    0 = encrypt, 1 = decrypt; valid with o_Start, held after
//   o_Key      out  128  key to AES core
//   o_Text     out  128  plaintext/ciphertext to AES core
//   o_Busy     out  1    high while AES operation outstanding
//   o_Err      out  1    one-cycle pulse on protocol error
// BEHAVIOUR
//   Reset (i_Rst=0, async): state IDLE, byte count 0, timeout count 0.
//     All outputs 0; partial frame discarded.
//   States: IDLE, PAYLOAD, WAIT.
//   IDLE, byte received:
//     - CMD_KEY/ENC/DEC: latch cmd, count=0, -> PAYLOAD.
//     - any other value: o_Err pulses next cycle, stay IDLE.
//   PAYLOAD, byte received:
//     - shift reg <= {sr[119:0], byte}; count++; timeout count cleared.
//     - first payload byte ends in bits [127:120].
//   PAYLOAD, 16th byte, at the sampling edge:
//     - CMD_KEY: o_Key <= assembled value; -> IDLE; no o_Start.
//     - ENC/DEC: o_Text <= assembled value, o_fDec <= (cmd==CMD_DEC),
//       o_Start <= 1 (exactly one cycle), o_Busy <= 1; -> WAIT.
//     - o_Start is high the cycle after the 16th byte is sampled.
//     - o_Key/o_Text/o_fDec are stable in that cycle and held until next update.
//   PAYLOAD, no byte received:
//     - timeout counter increments.
//     - when it reaches TIMEOUT_CYC: o_Err pulses, frame discarded, -> IDLE.
//   WAIT:
//     - o_Busy=1.
//     - Any received byte is dropped and o_Err pulses.
//     - On i_AesDone: o_Busy <= 0, -> IDLE.
//     - i_AesDone and i_RxValid in the same cycle: done is taken, the byte is
//       dropped and o_Err pulses.
//   o_Key is never modified while o_Busy=1, so the key is stable during an operation.
//   i_AesDone outside WAIT is ignored.
//   Timeout counter width: $clog2(TIMEOUT_CYC+1).
//   Byte counter: 4 bits plus terminal detect; no wrap beyond 16.
// TESTING
//   1 Key load: 4B, 2b 7e 15 16 28 ae d2 a6 ab f7 15 88 09 cf 4f 3c
//     -> o_Key=2b7e151628aed2a6abf7158809cf4f3c, no o_Start, o_Busy=0.
//   2 Encrypt: 45, 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34
//     -> one-cycle o_Start, o_fDec=0, o_Text=3243f6a8885a308d313198a2e0370734.
//     -> o_Busy stays 1 until i_AesDone; with the AES core attached the result
//        is 3925841d02dc09fbdc118597196a0b32.
//   3 Decrypt: 44, 39 25 84 1d 02 dc 09 fb dc 11 85 97 19 6a 0b 32
//     -> o_fDec=1, o_Text=3925...0b32; core result 3243f6a8...0734.
//   4 Bad command 0x00 -> o_Err one-cycle pulse, stays IDLE.
//     A following full encrypt frame still produces o_Start.
//   5 TIMEOUT_CYC=64: 45 + 5 bytes, then 64 idle cycles -> o_Err, no o_Start.
//     A fresh 17-byte frame then yields the correct o_Text.
//   6 Byte sent during WAIT -> o_Err, o_Text unchanged.
//     i_Rst=0 after 8 payload bytes -> all outputs 0 immediately; next frame correct.

Source files
------------

// File: rtl/aes_uart_frame_rx_if.sv
// Bundles the UART byte stream, the AES core done strobe and the command outputs
// that the frame receiver drives toward the AES core.
interface aes_uart_frame_rx_if;
  logic         i_RxValid;
  logic [7:0]   i_RxData;
  logic         i_AesDone;
  logic         o_Start;
  logic         o_fDec;
  logic [127:0] o_Key;
  logic [127:0] o_Text;
  logic         o_Busy;
  logic         o_Err;

  modport slave (
    input  i_RxValid, i_RxData, i_AesDone,
    output o_Start, o_fDec, o_Key, o_Text, o_Busy, o_Err
  );

  modport master (
    output i_RxValid, i_RxData, i_AesDone,
    input  o_Start, o_fDec, o_Key, o_Text, o_Busy, o_Err
  );
endinterface

// File: rtl/aes_uart_frame_rx.sv
// Assembles UART bytes into command frames (1 command byte + 16 payload bytes,
// MSB first) and issues key loads or encrypt/decrypt starts to the AES core.
module aes_uart_frame_rx #(
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] CMD_KEY     = 8'h4B,
  parameter logic [7:0] CMD_ENC     = 8'h45,
  parameter logic [7:0] CMD_DEC     = 8'h44
) (
  input logic                 i_Clk,
  input logic                 i_Rst,
  aes_uart_frame_rx_if.slave  bus
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    WAIT
  } state_t;

  state_t           state;
  logic [7:0]       cmd;
  logic [3:0]       byte_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [119:0]     sr;
  logic [127:0]     sr_next;
  logic             is_cmd;

  logic             start_r;
  logic             fdec_r;
  logic [127:0]     key_r;
  logic [127:0]     text_r;
  logic             busy_r;
  logic             err_r;

  // The 16th byte is merged combinationally so the full word lands in the
  // key/text register on the same edge that samples it.
  assign sr_next = {sr, bus.i_RxData};
  assign is_cmd  = (bus.i_RxData == CMD_KEY) || (bus.i_RxData == CMD_ENC) ||
                   (bus.i_RxData == CMD_DEC);

  always_ff @(posedge i_Clk) begin
    if (state == PAYLOAD && bus.i_RxValid) begin
      sr <= sr_next[119:0];
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state    <= IDLE;
      cmd      <= '0;
      byte_cnt <= '0;
      tmo_cnt  <= '0;
      start_r  <= 1'b0;
      fdec_r   <= 1'b0;
      key_r    <= '0;
      text_r   <= '0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      start_r <= 1'b0;
      err_r   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_RxValid) begin
            if (is_cmd) begin
              cmd      <= bus.i_RxData;
              byte_cnt <= '0;
              tmo_cnt  <= '0;
              state    <= PAYLOAD;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        PAYLOAD: begin
          if (bus.i_RxValid) begin
            tmo_cnt <= '0;
            if (byte_cnt == 4'd15) begin
              byte_cnt <= '0;
              if (cmd == CMD_KEY) begin
                key_r <= sr_next;
                state <= IDLE;
              end else begin
                text_r  <= sr_next;
                fdec_r  <= (cmd == CMD_DEC);
                start_r <= 1'b1;
                busy_r  <= 1'b1;
                state   <= WAIT;
              end
            end else begin
              byte_cnt <= byte_cnt + 4'd1;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Sender stalled mid-frame: drop the partial frame.
            err_r    <= 1'b1;
            tmo_cnt  <= '0;
            byte_cnt <= '0;
            state    <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (bus.i_RxValid) begin
            err_r <= 1'b1;
          end
          if (bus.i_AesDone) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_Start = start_r;
  assign bus.o_fDec  = fdec_r;
  assign bus.o_Key   = key_r;
  assign bus.o_Text  = text_r;
  assign bus.o_Busy  = busy_r;
  assign bus.o_Err   = err_r;

endmodule

// File: tb/tb_aes_uart_frame_rx.sv
// Bench for aes_uart_frame_rx: directed frames from the known-answer vectors,
// then randomized frames, all checked cycle by cycle against a byte-queue model.
module tb_aes_uart_frame_rx;
  localparam int TMO = 64;
  localparam logic [127:0] KEY_V = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_V  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_V  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  aes_uart_frame_rx_if bus();

  aes_uart_frame_rx #(.TIMEOUT_CYC(TMO)) dut (
    .i_Clk(clk),
    .i_Rst(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;
  int n_err    = 0;

  // Reference model: bytes of the frame in progress, plus the core-side view.
  logic [7:0]   q[$];
  int           idle;
  bit           m_busy;
  bit           m_fdec;
  logic [127:0] m_key;
  logic [127:0] m_text;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    idle   = 0;
    m_busy = 1'b0;
    m_fdec = 1'b0;
    m_key  = '0;
    m_text = '0;
  endtask

  task automatic model_step(input bit v, input logic [7:0] d, input bit done,
                            output bit es, output bit ee);
    logic [127:0] val;
    es = 1'b0;
    ee = 1'b0;
    if (m_busy) begin
      if (v) ee = 1'b1;
      if (done) m_busy = 1'b0;
    end else if (q.size() == 0) begin
      if (v) begin
        if (d == 8'h4B || d == 8'h45 || d == 8'h44) begin
          q.push_back(d);
          idle = 0;
        end else begin
          ee = 1'b1;
        end
      end
    end else if (v) begin
      q.push_back(d);
      idle = 0;
      if (q.size() == 17) begin
        val = '0;
        for (int i = 1; i <= 16; i++) val = val * 256 + 128'(q[i]);
        if (q[0] == 8'h4B) begin
          m_key = val;
        end else begin
          m_text = val;
          m_fdec = (q[0] == 8'h44);
          es     = 1'b1;
          m_busy = 1'b1;
        end
        q.delete();
      end
    end else begin
      idle++;
      if (idle == TMO) begin
        ee = 1'b1;
        q.delete();
      end
    end
  endtask

  task automatic cycle(input bit v, input logic [7:0] d, input bit done);
    bit es, ee;
    @(negedge clk);
    bus.i_RxValid = v;
    bus.i_RxData  = d;
    bus.i_AesDone = done;
    @(posedge clk);
    model_step(v, d, done, es, ee);
    #1;
    if (bus.o_Start) n_start++;
    if (bus.o_Err) n_err++;
    check("start", 128'(bus.o_Start), 128'(es));
    check("err",   128'(bus.o_Err),   128'(ee));
    check("busy",  128'(bus.o_Busy),  128'(m_busy));
    check("fdec",  128'(bus.o_fDec),  128'(m_fdec));
    check("key",   bus.o_Key,  m_key);
    check("text",  bus.o_Text, m_text);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.i_RxValid = 1'b0;
    bus.i_AesDone = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_start", 128'(bus.o_Start), 128'd0);
    check("rst_err",   128'(bus.o_Err),   128'd0);
    check("rst_busy",  128'(bus.o_Busy),  128'd0);
    check("rst_fdec",  128'(bus.o_fDec),  128'd0);
    check("rst_key",   bus.o_Key,  128'd0);
    check("rst_text",  bus.o_Text, 128'd0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [127:0] p, input int gap);
    cycle(1'b1, c, 1'b0);
    for (int i = 0; i < 16; i++) begin
      for (int g = 0; g < gap; g++) cycle(1'b0, 8'h00, 1'b0);
      cycle(1'b1, p[127-8*i -: 8], 1'b0);
    end
  endtask

  initial begin
    int s0, e0;
    logic [7:0]   rc;
    logic [127:0] rp;
    int           gap;

    bus.i_RxValid = 1'b0;
    bus.i_RxData  = 8'h00;
    bus.i_AesDone = 1'b0;
    model_clear();
    do_reset();

    // Key load
    send_frame(8'h4B, KEY_V, 0);
    cycle(1'b0, 8'h00, 1'b0);
    check("t1_key",  bus.o_Key, KEY_V);
    check("t1_busy", 128'(bus.o_Busy), 128'd0);

    // Encrypt, done arrives later
    s0 = n_start;
    send_frame(8'h45, PT_V, 1);
    check("t2_start_cnt", 128'(n_start - s0), 128'd1);
    check("t2_text", bus.o_Text, PT_V);
    repeat (5) cycle(1'b0, 8'h00, 1'b0);
    check("t2_busy_hold", 128'(bus.o_Busy), 128'd1);
    cycle(1'b0, 8'h00, 1'b1);
    check("t2_busy_clr", 128'(bus.o_Busy), 128'd0);

    // Decrypt
    send_frame(8'h44, CT_V, 0);
    check("t3_fdec", 128'(bus.o_fDec), 128'd1);
    check("t3_text", bus.o_Text, CT_V);
    check("t3_key",  bus.o_Key, KEY_V);
    cycle(1'b0, 8'h00, 1'b1);

    // Bad command then a good frame
    e0 = n_err;
    s0 = n_start;
    cycle(1'b1, 8'h00, 1'b0);
    check("t4_err", 128'(n_err - e0), 128'd1);
    send_frame(8'h45, PT_V, 0);
    check("t4_start", 128'(n_start - s0), 128'd1);
    cycle(1'b0, 8'h00, 1'b1);

    // Timeout mid-frame, then a fresh frame
    e0 = n_err;
    s0 = n_start;
    cycle(1'b1, 8'h45, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i + 1), 1'b0);
    repeat (TMO) cycle(1'b0, 8'h00, 1'b0);
    check("t5_err", 128'(n_err - e0), 128'd1);
    check("t5_nostart", 128'(n_start - s0), 128'd0);
    send_frame(8'h45, PT_V, 0);
    check("t5_text", bus.o_Text, PT_V);

    // Byte during WAIT, then reset mid-frame
    e0 = n_err;
    cycle(1'b1, 8'hAA, 1'b0);
    check("t6_err", 128'(n_err - e0), 128'd1);
    check("t6_text", bus.o_Text, PT_V);
    cycle(1'b0, 8'h00, 1'b1);
    cycle(1'b1, 8'h45, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);
    do_reset();
    send_frame(8'h4B, KEY_V, 0);
    check("t6_key", bus.o_Key, KEY_V);

    // Randomized frames with gaps, timeouts, stray bytes and done strobes
    for (int f = 0; f < 60; f++) begin
      case ($urandom_range(0, 4))
        0: rc = 8'h4B;
        1, 2: rc = 8'h45;
        3: rc = 8'h44;
        default: rc = 8'($urandom);
      endcase
      rp = {$urandom, $urandom, $urandom, $urandom};
      cycle(1'b1, rc, 1'b0);
      for (int i = 0; i < 16; i++) begin
        gap = ($urandom_range(0, 59) == 0) ? TMO + 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) cycle(1'b0, 8'h00, ($urandom_range(0, 7) == 0));
        cycle(1'b1, rp[127-8*i -: 8], 1'b0);
      end
      for (int t = 0; t < int'($urandom_range(1, 12)); t++)
        cycle(($urandom_range(0, 7) == 0), 8'($urandom), ($urandom_range(0, 3) == 0));
      if (m_busy) cycle(1'b0, 8'h00, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
